// File: rtl/vproc_vreg_rd_arb_pkg.sv
// Shared types and helpers for the vector register read arbiter.
package vproc_vreg_rd_arb_pkg;

   localparam int unsigned VREG_ADDR_W = 5;

   typedef logic [VREG_ADDR_W-1:0] vreg_addr_t;

   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned cnt);
      return (idx + 1 >= cnt) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/vproc_vreg_rd_arb_if.sv
// Pipeline-side request/response bundle of the vector register read arbiter.
interface vproc_vreg_rd_arb_if #(
   parameter int unsigned PIPE_CNT = 2,
   parameter int unsigned VREG_W   = 128
);
   import vproc_vreg_rd_arb_pkg::*;

   logic [PIPE_CNT-1:0]                  vreg_rd_valid;
   logic [PIPE_CNT-1:0]                  vreg_rd_ready;
   logic [PIPE_CNT-1:0][VREG_ADDR_W-1:0] vreg_rd_addr;
   logic [PIPE_CNT-1:0]                  vreg_rd_rvalid;
   logic [PIPE_CNT-1:0]                  vreg_rd_rready;
   logic [PIPE_CNT-1:0][VREG_W-1:0]      vreg_rd_rdata;

   modport master (
      output vreg_rd_valid, vreg_rd_addr, vreg_rd_rready,
      input  vreg_rd_ready, vreg_rd_rvalid, vreg_rd_rdata
   );

   modport slave (
      input  vreg_rd_valid, vreg_rd_addr, vreg_rd_rready,
      output vreg_rd_ready, vreg_rd_rvalid, vreg_rd_rdata
   );

endinterface

// File: rtl/vproc_vreg_rd_arb_resp_buf.sv
// Per-pipeline response FIFO; head is visible on data/valid, occupancy on count.
module vproc_rd_resp_buf #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk_i,
   input  logic                         async_rst_ni,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic                         valid,
   output logic [WIDTH-1:0]             data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             pop_en;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign pop_en = pop & valid;
   assign valid  = (cnt != '0);
   assign data   = mem[rd_ptr];
   assign count  = cnt;

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push)   wr_ptr <= ptr_inc(wr_ptr);
         if (pop_en) rd_ptr <= ptr_inc(rd_ptr);
         cnt <= cnt + CNT_W'(push) - CNT_W'(pop_en);
      end
   end

   assert property (@(posedge clk_i) disable iff (!async_rst_ni)
      !(push && (cnt == CNT_W'(DEPTH)) && !pop_en));

endmodule

// File: rtl/vproc_vreg_rd_arb.sv
// Arbitrates pipeline vreg reads onto register file read ports and returns the data
// through per-pipeline credit-limited response buffers.
module vproc_vreg_rd_arb
   import vproc_vreg_rd_arb_pkg::*;
#(
   parameter int unsigned                         VREG_W          = 128,
   parameter int unsigned                         VPORT_RD_CNT    = 1,
   parameter int unsigned                         PIPE_CNT        = 2,
   parameter bit [VPORT_RD_CNT-1:0][PIPE_CNT-1:0] VPORT_RD_MAP    = '0,
   parameter int unsigned                         VREGFILE_RD_LAT = 1,
   parameter int unsigned                         RESP_DEPTH      = 2,
   parameter bit                                  DONT_CARE_ZERO  = 1'b0
) (
   input  logic                                      clk_i,
   input  logic                                      async_rst_ni,
   vproc_vreg_rd_arb_if.slave                        rd,
   output logic [VPORT_RD_CNT-1:0][VREG_ADDR_W-1:0]  vregfile_rd_addr_o,
   input  logic [VPORT_RD_CNT-1:0][VREG_W-1:0]       vregfile_rd_data_i
);
   localparam int unsigned PIPE_IDX_W = (PIPE_CNT > 1) ? $clog2(PIPE_CNT) : 1;
   localparam int unsigned CRED_W     = $clog2(RESP_DEPTH + 1);
   localparam int unsigned SUM_W      = CRED_W + 1;

   typedef logic [PIPE_IDX_W-1:0] pipe_idx_t;

   pipe_idx_t                         rr_q       [VPORT_RD_CNT];
   logic [VREGFILE_RD_LAT-1:0]        sr_valid_q [VPORT_RD_CNT];
   pipe_idx_t                         sr_pipe_q  [VPORT_RD_CNT][VREGFILE_RD_LAT];
   logic [CRED_W-1:0]                 inflight_q [PIPE_CNT];
   logic [CRED_W-1:0]                 count      [PIPE_CNT];

   logic [PIPE_CNT-1:0]               eligible, granted, push, pop, mapped;
   logic [PIPE_CNT-1:0][VREG_W-1:0]   push_data;
   logic [VPORT_RD_CNT-1:0]           port_gnt;
   pipe_idx_t                         port_win   [VPORT_RD_CNT];

   // Credits use registered occupancy, so a pop only frees a slot from the next cycle on.
   always_comb begin
      eligible = '0;
      for (int unsigned j = 0; j < PIPE_CNT; j++) begin
         eligible[j] = rd.vreg_rd_valid[j] &&
                       ((SUM_W'(inflight_q[j]) + SUM_W'(count[j])) < SUM_W'(RESP_DEPTH));
      end
   end

   always_comb begin
      int unsigned cand;
      pipe_idx_t   cidx;
      cand     = 0;
      cidx     = '0;
      granted  = '0;
      port_gnt = '0;
      for (int unsigned i = 0; i < VPORT_RD_CNT; i++) port_win[i] = '0;
      for (int unsigned i = 0; i < VPORT_RD_CNT; i++) begin
         for (int unsigned k = 0; k < PIPE_CNT; k++) begin
            cand = 32'(rr_q[i]) + k;
            if (cand >= PIPE_CNT) cand = cand - PIPE_CNT;
            cidx = pipe_idx_t'(cand);
            if (!port_gnt[i] && VPORT_RD_MAP[i][cidx] && eligible[cidx] && !granted[cidx]) begin
               port_gnt[i]   = 1'b1;
               port_win[i]   = cidx;
               granted[cidx] = 1'b1;
            end
         end
      end
   end

   assign rd.vreg_rd_ready = granted;
   assign pop              = rd.vreg_rd_rvalid & rd.vreg_rd_rready;

   always_comb begin
      for (int unsigned i = 0; i < VPORT_RD_CNT; i++) begin
         vregfile_rd_addr_o[i] = DONT_CARE_ZERO ? '0 : 'x;
         if (port_gnt[i]) vregfile_rd_addr_o[i] = rd.vreg_rd_addr[port_win[i]];
      end
   end

   // At most one grant per pipeline per cycle and a shared latency mean at most one port
   // can retire into a given pipeline in any cycle.
   always_comb begin
      push      = '0;
      push_data = '0;
      for (int unsigned i = 0; i < VPORT_RD_CNT; i++) begin
         if (sr_valid_q[i][VREGFILE_RD_LAT-1]) begin
            push[sr_pipe_q[i][VREGFILE_RD_LAT-1]]      = 1'b1;
            push_data[sr_pipe_q[i][VREGFILE_RD_LAT-1]] = vregfile_rd_data_i[i];
         end
      end
   end

   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         for (int unsigned i = 0; i < VPORT_RD_CNT; i++) begin
            rr_q[i]       <= '0;
            sr_valid_q[i] <= '0;
            for (int unsigned s = 0; s < VREGFILE_RD_LAT; s++) sr_pipe_q[i][s] <= '0;
         end
         for (int unsigned j = 0; j < PIPE_CNT; j++) inflight_q[j] <= '0;
      end else begin
         for (int unsigned i = 0; i < VPORT_RD_CNT; i++) begin
            if (port_gnt[i]) rr_q[i] <= pipe_idx_t'(wrap_inc(32'(port_win[i]), PIPE_CNT));
            sr_valid_q[i][0] <= port_gnt[i];
            sr_pipe_q[i][0]  <= port_win[i];
            for (int unsigned s = 1; s < VREGFILE_RD_LAT; s++) begin
               sr_valid_q[i][s] <= sr_valid_q[i][s-1];
               sr_pipe_q[i][s]  <= sr_pipe_q[i][s-1];
            end
         end
         for (int unsigned j = 0; j < PIPE_CNT; j++) begin
            inflight_q[j] <= inflight_q[j] + CRED_W'(granted[j]) - CRED_W'(push[j]);
         end
      end
   end

   for (genvar j = 0; j < PIPE_CNT; j++) begin : g_buf
      vproc_rd_resp_buf #(
         .WIDTH (VREG_W),
         .DEPTH (RESP_DEPTH)
      ) u_buf (
         .clk_i        (clk_i),
         .async_rst_ni (async_rst_ni),
         .push         (push[j]),
         .push_data    (push_data[j]),
         .pop          (pop[j]),
         .valid        (rd.vreg_rd_rvalid[j]),
         .data         (rd.vreg_rd_rdata[j]),
         .count        (count[j])
      );
   end

   always_comb begin
      mapped = '0;
      for (int unsigned i = 0; i < VPORT_RD_CNT; i++) mapped = mapped | VPORT_RD_MAP[i];
   end

   assert property (@(posedge clk_i) disable iff (!async_rst_ni)
      (rd.vreg_rd_valid & ~mapped) == '0);

endmodule

// File: tb/tb_vproc_vreg_rd_arb.sv
// Bench for vproc_vreg_rd_arb: a 1-port/LAT=1 instance and a 2-port/LAT=3 instance,
// table-driven cycle vectors plus directed sequences, with a per-pipeline data scoreboard.
module tb_vproc_vreg_rd_arb;
   import vproc_vreg_rd_arb_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   vproc_vreg_rd_arb_if #(.PIPE_CNT(2), .VREG_W(128)) ifa ();
   vproc_vreg_rd_arb_if #(.PIPE_CNT(2), .VREG_W(128)) ifb ();

   logic [0:0][4:0]   a_rf_addr;
   logic [0:0][127:0] a_rf_data;
   logic [1:0][4:0]   b_rf_addr;
   logic [1:0][127:0] b_rf_data;

   vproc_vreg_rd_arb #(
      .VREG_W          (128),
      .VPORT_RD_CNT    (1),
      .PIPE_CNT        (2),
      .VPORT_RD_MAP    (2'b11),
      .VREGFILE_RD_LAT (1),
      .RESP_DEPTH      (2),
      .DONT_CARE_ZERO  (1'b1)
   ) dut_a (
      .clk_i              (clk),
      .async_rst_ni       (rst_n),
      .rd                 (ifa),
      .vregfile_rd_addr_o (a_rf_addr),
      .vregfile_rd_data_i (a_rf_data)
   );

   // port 0: pipe 0 only; port 1: pipes 0 and 1
   vproc_vreg_rd_arb #(
      .VREG_W          (128),
      .VPORT_RD_CNT    (2),
      .PIPE_CNT        (2),
      .VPORT_RD_MAP    (4'b11_01),
      .VREGFILE_RD_LAT (3),
      .RESP_DEPTH      (2),
      .DONT_CARE_ZERO  (1'b0)
   ) dut_b (
      .clk_i              (clk),
      .async_rst_ni       (rst_n),
      .rd                 (ifb),
      .vregfile_rd_addr_o (b_rf_addr),
      .vregfile_rd_data_i (b_rf_data)
   );

   function automatic logic [127:0] tag(input logic [4:0] a);
      logic [127:0] t;
      t = '0;
      for (int b = 0; b < 16; b++) t[b*8 +: 8] = {3'b101, a};
      return t;
   endfunction

   // Register file models returning address-tagged data after the configured latency
   logic [4:0] a_stage;
   logic [4:0] b_stage [2][3];
   always_ff @(posedge clk) begin
      a_stage <= a_rf_addr[0];
      for (int p = 0; p < 2; p++) begin
         b_stage[p][0] <= b_rf_addr[p];
         b_stage[p][1] <= b_stage[p][0];
         b_stage[p][2] <= b_stage[p][1];
      end
   end
   always_comb begin
      a_rf_data[0] = tag(a_stage);
      for (int p = 0; p < 2; p++) b_rf_data[p] = tag(b_stage[p][2]);
   end

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   logic [127:0] expq [2][2][$];

   task automatic mon(input int d, input logic [1:0] v, input logic [1:0] r,
                      input logic [1:0] rv, input logic [1:0] rr,
                      input logic [1:0][4:0] ad, input logic [1:0][127:0] rdat);
      for (int j = 0; j < 2; j++) begin
         if (rv[j] && rr[j]) begin
            if (expq[d][j].size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_resp dut%0d pipe%0d: got %0h expected none", d, j, rdat[j]);
            end else begin
               check($sformatf("resp_data dut%0d pipe%0d", d, j), rdat[j], expq[d][j].pop_front());
            end
         end
         if (v[j] && r[j]) expq[d][j].push_back(tag(ad[j]));
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++)
            for (int j = 0; j < 2; j++) expq[d][j].delete();
      end else begin
         mon(0, ifa.vreg_rd_valid, ifa.vreg_rd_ready, ifa.vreg_rd_rvalid, ifa.vreg_rd_rready,
             ifa.vreg_rd_addr, ifa.vreg_rd_rdata);
         mon(1, ifb.vreg_rd_valid, ifb.vreg_rd_ready, ifb.vreg_rd_rvalid, ifb.vreg_rd_rready,
             ifb.vreg_rd_addr, ifb.vreg_rd_rdata);
      end
   end

   typedef struct {
      logic [1:0] valid;
      logic [1:0] rready;
      logic [4:0] a0;
      logic [4:0] a1;
      logic [1:0] exp_ready;
      logic [1:0] exp_rvalid;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [1:0] v, input logic [1:0] rr, input logic [4:0] a0,
                               input logic [4:0] a1, input logic [1:0] er, input logic [1:0] ev);
      vec_t t;
      t.valid = v; t.rready = rr; t.a0 = a0; t.a1 = a1; t.exp_ready = er; t.exp_rvalid = ev;
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int unsigned seq [6] = '{4, 8, 15, 16, 23, 30};
      logic [4:0]  exp_addr;
      int          n;
      bit          got;

      // both pipes streaming on dut_a: grants alternate, rvalid two cycles after grant
      for (int r = 0; r < 9; r++) begin
         vecs.push_back(mk((r < 6) ? 2'b11 : 2'b00, 2'b11, 5'(r + 1), 5'(r + 16),
                           (r >= 6) ? 2'b00 : ((r % 2 == 0) ? 2'b01 : 2'b10),
                           (r < 2 || r == 8) ? 2'b00 : ((r % 2 == 0) ? 2'b01 : 2'b10)));
      end
      // pipe 0 reads 5,7,9 with rready low: two credits, third waits for a pop
      vecs.push_back(mk(2'b01, 2'b00, 5'd5, 5'd0, 2'b01, 2'b00));
      vecs.push_back(mk(2'b01, 2'b00, 5'd7, 5'd0, 2'b01, 2'b00));
      vecs.push_back(mk(2'b01, 2'b00, 5'd9, 5'd0, 2'b00, 2'b01));
      vecs.push_back(mk(2'b01, 2'b00, 5'd9, 5'd0, 2'b00, 2'b01));
      vecs.push_back(mk(2'b01, 2'b01, 5'd9, 5'd0, 2'b00, 2'b01));
      vecs.push_back(mk(2'b01, 2'b00, 5'd9, 5'd0, 2'b01, 2'b01));
      vecs.push_back(mk(2'b00, 2'b01, 5'd0, 5'd0, 2'b00, 2'b01));
      vecs.push_back(mk(2'b00, 2'b01, 5'd0, 5'd0, 2'b00, 2'b01));
      vecs.push_back(mk(2'b00, 2'b01, 5'd0, 5'd0, 2'b00, 2'b00));

      ifa.vreg_rd_valid = '0; ifa.vreg_rd_addr = '0; ifa.vreg_rd_rready = '0;
      ifb.vreg_rd_valid = '0; ifb.vreg_rd_addr = '0; ifb.vreg_rd_rready = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset rvalid_a", ifa.vreg_rd_rvalid, 2'b00);
      check("reset rvalid_b", ifb.vreg_rd_rvalid, 2'b00);
      check("reset ready_a", ifa.vreg_rd_ready, 2'b00);
      check("reset rf_addr_a", a_rf_addr[0], 5'd0);
      tick();
      rst_n = 1'b1;

      foreach (vecs[r]) begin
         ifa.vreg_rd_valid   = vecs[r].valid;
         ifa.vreg_rd_rready  = vecs[r].rready;
         ifa.vreg_rd_addr[0] = vecs[r].a0;
         ifa.vreg_rd_addr[1] = vecs[r].a1;
         @(negedge clk);
         check($sformatf("vec%0d ready", r), ifa.vreg_rd_ready, vecs[r].exp_ready);
         check($sformatf("vec%0d rvalid", r), ifa.vreg_rd_rvalid, vecs[r].exp_rvalid);
         exp_addr = vecs[r].exp_ready[0] ? vecs[r].a0 : (vecs[r].exp_ready[1] ? vecs[r].a1 : 5'd0);
         check($sformatf("vec%0d rf_addr", r), a_rf_addr[0], exp_addr);
         tick();
      end
      ifa.vreg_rd_valid = '0; ifa.vreg_rd_rready = '0;

      // dual port grant in one cycle, then LAT=3 response at t+4
      ifb.vreg_rd_valid   = 2'b11;
      ifb.vreg_rd_addr[0] = 5'd3;
      ifb.vreg_rd_addr[1] = 5'd12;
      @(negedge clk);
      check("dual ready", ifb.vreg_rd_ready, 2'b11);
      check("dual rf_addr0", b_rf_addr[0], 5'd3);
      check("dual rf_addr1", b_rf_addr[1], 5'd12);
      tick();
      ifb.vreg_rd_valid = '0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check($sformatf("lat3 rvalid t+%0d", k), ifb.vreg_rd_rvalid, (k == 4) ? 2'b11 : 2'b00);
         tick();
      end
      ifb.vreg_rd_rready = 2'b11;
      tick();

      // ordered stream on pipe 0 while pipe 1 competes on port 1
      ifb.vreg_rd_valid[1] = 1'b1;
      ifb.vreg_rd_addr[1]  = 5'd21;
      foreach (seq[s]) begin
         ifb.vreg_rd_valid[0] = 1'b1;
         ifb.vreg_rd_addr[0]  = 5'(seq[s]);
         got = 1'b0;
         for (int w = 0; w < 20 && !got; w++) begin
            @(negedge clk);
            got = ifb.vreg_rd_ready[0];
            tick();
         end
         if (!got) check($sformatf("stream%0d accept", s), 1'b0, 1'b1);
      end
      ifb.vreg_rd_valid = '0;
      repeat (8) tick();
      check("stream drain q0", expq[1][0].size(), 0);
      check("stream drain q1", expq[1][1].size(), 0);
      ifb.vreg_rd_rready = '0;

      // random traffic on dut_a, data checked by the scoreboard
      for (int c = 0; c < 100; c++) begin
         ifa.vreg_rd_valid   = 2'($urandom_range(0, 3));
         ifa.vreg_rd_rready  = 2'($urandom_range(0, 3));
         ifa.vreg_rd_addr[0] = 5'($urandom);
         ifa.vreg_rd_addr[1] = 5'($urandom);
         @(negedge clk);
         check("ready_without_valid", ifa.vreg_rd_ready & ~ifa.vreg_rd_valid, 2'b00);
         tick();
      end
      ifa.vreg_rd_valid = '0; ifa.vreg_rd_rready = 2'b11;
      repeat (6) tick();
      check("rand drain q0", expq[0][0].size(), 0);
      check("rand drain q1", expq[0][1].size(), 0);

      // every credit must have come back: exactly RESP_DEPTH grants with no pops
      ifa.vreg_rd_rready = '0;
      for (int p = 0; p < 2; p++) begin
         ifa.vreg_rd_valid = (p == 0) ? 2'b01 : 2'b10;
         n = 0;
         repeat (6) begin
            @(negedge clk);
            if (ifa.vreg_rd_ready[p]) n++;
            tick();
         end
         check($sformatf("credits pipe%0d", p), n, 2);
      end
      ifa.vreg_rd_valid = '0; ifa.vreg_rd_rready = 2'b11;
      repeat (6) tick();
      ifa.vreg_rd_rready = '0;

      // reset with reads in flight: dut_a rr moved to 1, dut_b has two LAT=3 reads pending
      ifa.vreg_rd_valid   = 2'b01;
      ifb.vreg_rd_valid   = 2'b11;
      ifb.vreg_rd_addr[0] = 5'd1;
      ifb.vreg_rd_addr[1] = 5'd2;
      @(negedge clk);
      check("pre-reset ready_a", ifa.vreg_rd_ready, 2'b01);
      check("pre-reset ready_b", ifb.vreg_rd_ready, 2'b11);
      tick();
      ifa.vreg_rd_valid = '0;
      ifb.vreg_rd_valid = '0;
      tick();
      check("pre-reset rvalid_a", ifa.vreg_rd_rvalid, 2'b01);
      #2;
      rst_n = 1'b0;
      #1;
      check("in-reset rvalid_a", ifa.vreg_rd_rvalid, 2'b00);
      check("in-reset rvalid_b", ifb.vreg_rd_rvalid, 2'b00);
      tick();
      rst_n = 1'b1;
      ifa.vreg_rd_rready = 2'b11;
      ifb.vreg_rd_rready = 2'b11;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("post-reset rvalid_a c%0d", k), ifa.vreg_rd_rvalid, 2'b00);
         check($sformatf("post-reset rvalid_b c%0d", k), ifb.vreg_rd_rvalid, 2'b00);
         tick();
      end
      ifa.vreg_rd_valid = 2'b11;
      ifb.vreg_rd_valid = 2'b11;
      @(negedge clk);
      check("post-reset rr ready_a", ifa.vreg_rd_ready, 2'b01);
      check("post-reset ready_b", ifb.vreg_rd_ready, 2'b11);
      tick();
      ifa.vreg_rd_valid = '0;
      ifb.vreg_rd_valid = '0;
      repeat (8) tick();

      for (int d = 0; d < 2; d++)
         for (int j = 0; j < 2; j++)
            check($sformatf("final q dut%0d pipe%0d", d, j), expq[d][j].size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
